spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- Mode-0 SPI master that drives sclk/ss_n/mosi into the existing SPI slave and captures its miso.
- Sits between on-chip logic (parallel word, start/done handshake) and the SPI pins; the upstream stage that feeds the slave.
- One word of BITS bits per transaction, MSB first. Full-duplex: tx_data shifts out while rx_data shifts in.

Parameters:
- BITS, 8, word length in bits (>=2)
- CLK_DIV, 2, sclk half-period in clk cycles (>=1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request transaction; accepted only when busy=0
- tx_data  input  BITS  word to send; sampled on the accepting edge
- rx_data  output  BITS  last received word; updated in the done cycle
- busy  output  1  high from the cycle after acceptance until done
- done  output  1  one-cycle pulse at transaction end
- sclk  output  1  SPI clock, idle low
- ss_n  output  1  active-low slave select
- mosi  output  1  serial data to slave
- miso  input  1  serial data from slave

Behaviour:
- Reset values: sclk=0, ss_n=1, mosi=0, busy=0, done=0, rx_data=0; state IDLE, counters 0.
- Rst during a transfer aborts it. On the next edge ss_n=1 and sclk=0. No done pulse; rx_data is not updated.
- Half-period counter: 0..CLK_DIV-1, width $clog2(CLK_DIV+1). A tick fires when the counter reaches CLK_DIV-1, then wraps to 0.
- States:
  - IDLE: on start with busy=0, latch tx_data into the shift register. Next cycle: ss_n=0, mosi=tx_data[BITS-1], busy=1. Go to SETUP.
  - SETUP: sclk=0 for CLK_DIV cycles. On tick go to HIGH.
  - HIGH: sclk=1 for CLK_DIV cycles. miso is shifted into the rx shift register on the edge that raises sclk. On tick go to LOW.
  - LOW: sclk=0 for CLK_DIV cycles. mosi shows the next bit from the edge that lowers sclk. On tick: if bit count < BITS go to HIGH, else go to END.
  - END (one cycle): ss_n=1, mosi=0, busy=0, done=1, rx_data = rx shift register. Next state IDLE.
- The final LOW phase provides the ss_n hold time. ss_n stays low for exactly CLK_DIV*(2*BITS+1) cycles (34 at defaults).
- A start asserted in the done cycle is accepted, since busy=0. ss_n is then high for exactly 1 cycle between words.
- start while busy=1 is ignored and not queued. tx_data changes while busy have no effect.
- Bit counter: width $clog2(BITS+1). Increments on each HIGH entry; cleared on acceptance.
- mosi and sclk are registered outputs with no combinational path from inputs.

Optional Feature:
- Macro: SPI_MASTER_LSB_FIRST_EN.
  - Defined: tx shifts out LSB first (first mosi bit is tx_data[0]). rx bits enter from the MSB end, so the first received bit lands in rx_data[0].
  - Undefined: MSB first, as above.
- Timing, handshake and reset behaviour are identical in both builds.

Decomposition:
- Shared package spi_pkg:
  - state enum typedef (IDLE, SETUP, HIGH, LOW, END)
  - default BITS constant
  - localparam helpers for counter widths
- One natural sub-module: spi_clk_div, a half-period tick generator with inputs clk, rst, en, parameter CLK_DIV and output tick. It is reused by a future slave-side rewrite.

Test Plan:
- Loopback miso=mosi, CLK_DIV=2, tx_data=8'hAC, start for 1 cycle -> 8 sclk rising edges, ss_n low 34 cycles, done pulse 1 cycle, rx_data=8'hAC, busy low with done.
- miso tied 1, tx_data=8'h00 -> mosi low throughout, rx_data=8'hFF. miso tied 0 -> rx_data=8'h00.
- Start pulses every cycle during a transfer with a differing tx_data -> exactly one transaction; second word begins only after done.
- CLK_DIV=1, back-to-back 8'h5A then 8'hC3 (start held high) -> sclk period 2 cycles, ss_n high exactly 1 cycle between words, rx sequence 5A, C3 in loopback.
- Rst asserted at the 4th sclk rising edge -> next cycle ss_n=1, sclk=0, busy=0, no done, rx_data keeps its prior value. A fresh 8'h0F transfer then completes correctly.
- With SPI_MASTER_LSB_FIRST_EN, tx 8'h01 in loopback -> first mosi bit 1, rest 0, rx_data=8'h01.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared types and width helpers for the SPI master and its clock divider.
// Pure declarations: no logic, no latency, no flow control.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    END
  } state_t;

  localparam int DEFAULT_BITS = 8;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Parallel-side handshake plus SPI pin bundle between on-chip logic and the master.
// Wiring only; the master owns all timing and ignores start while busy.
interface spi_master_if
  import spi_pkg::*;
#(
  parameter int BITS = DEFAULT_BITS
);

  logic            start;
  logic [BITS-1:0] tx_data;
  logic [BITS-1:0] rx_data;
  logic            busy;
  logic            done;
  logic            sclk;
  logic            ss_n;
  logic            mosi;
  logic            miso;

  modport master (
    input  start, tx_data, miso,
    output rx_data, busy, done, sclk, ss_n, mosi
  );

  modport slave (
    output start, tx_data, miso,
    input  rx_data, busy, done, sclk, ss_n, mosi
  );

endinterface

// File: rtl/spi_master_clk_div.sv
// Half-period tick generator: tick is high on every CLK_DIV-th enabled cycle.
// Combinational tick from a registered count; counter parks at 0 while en is low.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            CW   = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || !en || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master, one BITS-wide full-duplex word per start; SPI_MASTER_LSB_FIRST_EN selects LSB-first.
// Word takes CLK_DIV*(2*BITS+1)+1 cycles to done; start is accepted only while busy is low, never queued.
module spi_master
  import spi_pkg::*;
#(
  parameter int BITS    = DEFAULT_BITS,
  parameter int CLK_DIV = 2
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.master bus
);

  localparam int            BW     = cnt_w(BITS);
  localparam logic [BW-1:0] BITS_L = BW'(BITS);

  state_t          r_state, w_state_nxt;
  logic [BITS-1:0] r_tx_sr, w_tx_sr_nxt;
  logic [BITS-1:0] r_rx_sr, w_rx_sr_nxt;
  logic [BITS-1:0] r_rx_data, w_rx_data_nxt;
  logic [BW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic            r_sclk, w_sclk_nxt;
  logic            r_ss_n, w_ss_n_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            w_en, w_tick, w_mosi;
  logic [BITS-1:0] w_tx_shift, w_rx_shift;

  assign w_en = (r_state == SETUP) || (r_state == HIGH) || (r_state == LOW);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .en   (w_en),
    .tick (w_tick)
  );

  // mosi is the outgoing end of the tx shift register, so it is a plain flop output.
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign w_mosi     = r_tx_sr[0];
  assign w_tx_shift = {1'b0, r_tx_sr[BITS-1:1]};
  assign w_rx_shift = {bus.miso, r_rx_sr[BITS-1:1]};
`else
  assign w_mosi     = r_tx_sr[BITS-1];
  assign w_tx_shift = {r_tx_sr[BITS-2:0], 1'b0};
  assign w_rx_shift = {r_rx_sr[BITS-2:0], bus.miso};
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_tx_sr_nxt   = r_tx_sr;
    w_rx_sr_nxt   = r_rx_sr;
    w_rx_data_nxt = r_rx_data;
    w_bit_cnt_nxt = r_bit_cnt;
    w_sclk_nxt    = r_sclk;
    w_ss_n_nxt    = r_ss_n;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    unique case (r_state)
      IDLE, END: begin
        w_state_nxt = IDLE;
        if (bus.start) begin
          w_state_nxt   = SETUP;
          w_tx_sr_nxt   = bus.tx_data;
          w_rx_sr_nxt   = '0;
          w_bit_cnt_nxt = '0;
          w_ss_n_nxt    = 1'b0;
          w_busy_nxt    = 1'b1;
        end
      end
      SETUP: begin
        if (w_tick) begin
          w_state_nxt   = HIGH;
          w_sclk_nxt    = 1'b1;
          w_rx_sr_nxt   = w_rx_shift;
          w_bit_cnt_nxt = r_bit_cnt + BW'(1);
        end
      end
      HIGH: begin
        if (w_tick) begin
          w_state_nxt = LOW;
          w_sclk_nxt  = 1'b0;
          w_tx_sr_nxt = w_tx_shift;
        end
      end
      LOW: begin
        if (w_tick) begin
          if (r_bit_cnt < BITS_L) begin
            w_state_nxt   = HIGH;
            w_sclk_nxt    = 1'b1;
            w_rx_sr_nxt   = w_rx_shift;
            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
          end else begin
            w_state_nxt   = END;
            w_tx_sr_nxt   = '0;
            w_ss_n_nxt    = 1'b1;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b1;
            w_rx_data_nxt = r_rx_sr;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_bit_cnt <= '0;
      r_sclk    <= 1'b0;
      r_ss_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      // An aborted transfer keeps the last good word; a reset seen while idle clears it.
      if (!w_en) begin
        r_rx_data <= '0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_tx_sr   <= w_tx_sr_nxt;
      r_rx_sr   <= w_rx_sr_nxt;
      r_rx_data <= w_rx_data_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_sclk    <= w_sclk_nxt;
      r_ss_n    <= w_ss_n_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign bus.rx_data = r_rx_data;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.sclk    = r_sclk;
  assign bus.ss_n    = r_ss_n;
  assign bus.mosi    = w_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=2 and CLK_DIV=1) checked every cycle
// against a phase-arithmetic model, plus directed scenarios with literal expectations.
module tb_spi_master;

  localparam int B = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_d   [2];
  logic         start_d [2];
  logic [B-1:0] tx_d    [2];
  int           mode    [2];   // miso source: 0 loopback, 1 tied high, 2 tied low, 3 random
  logic         rnd_miso[2];

  logic         o_sclk[2], o_ss_n[2], o_mosi[2], o_busy[2], o_done[2], i_miso[2];
  logic [B-1:0] o_rx[2];

  spi_master_if #(.BITS(B)) bus0 ();
  spi_master_if #(.BITS(B)) bus1 ();

  spi_master #(.BITS(B), .CLK_DIV(2)) dut0 (.clk(clk), .rst(rst_d[0]), .bus(bus0.master));
  spi_master #(.BITS(B), .CLK_DIV(1)) dut1 (.clk(clk), .rst(rst_d[1]), .bus(bus1.master));

  assign bus0.start   = start_d[0];
  assign bus0.tx_data = tx_d[0];
  assign bus0.miso    = (mode[0] == 0) ? bus0.mosi : (mode[0] == 1) ? 1'b1 :
                        (mode[0] == 2) ? 1'b0 : rnd_miso[0];
  assign bus1.start   = start_d[1];
  assign bus1.tx_data = tx_d[1];
  assign bus1.miso    = (mode[1] == 0) ? bus1.mosi : (mode[1] == 1) ? 1'b1 :
                        (mode[1] == 2) ? 1'b0 : rnd_miso[1];

  assign o_sclk[0] = bus0.sclk;  assign o_sclk[1] = bus1.sclk;
  assign o_ss_n[0] = bus0.ss_n;  assign o_ss_n[1] = bus1.ss_n;
  assign o_mosi[0] = bus0.mosi;  assign o_mosi[1] = bus1.mosi;
  assign o_busy[0] = bus0.busy;  assign o_busy[1] = bus1.busy;
  assign o_done[0] = bus0.done;  assign o_done[1] = bus1.done;
  assign o_rx[0]   = bus0.rx_data; assign o_rx[1] = bus1.rx_data;
  assign i_miso[0] = bus0.miso;  assign i_miso[1] = bus1.miso;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 30) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // k = cycles since the accepting edge (0 idle); phase p = (k-1)/CLK_DIV counts
  // SETUP(0), then alternating HIGH(odd)/LOW(even) phases, END is cycle L+1.
  int           k    [2] = '{0, 0};
  logic [B-1:0] txw  [2];
  logic [B-1:0] racc [2];
  logic [B-1:0] rexp [2] = '{8'h00, 8'h00};
  bit           chk_en = 1'b0;

  function automatic int cdv(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic tbit(input logic [B-1:0] w, input int j);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return w[j];
`else
    return w[B-1-j];
`endif
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int cd, len, p;
      logic e_sclk, e_ss, e_mosi, e_busy, e_done;
      cd  = cdv(i);
      len = cd * (2 * B + 1);
      p   = (k[i] > 0) ? (k[i] - 1) / cd : 0;
      e_sclk = 1'b0; e_ss = 1'b1; e_mosi = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      if (k[i] >= 1 && k[i] <= len) begin
        e_sclk = (p % 2 == 1);
        e_ss   = 1'b0;
        e_busy = 1'b1;
        e_mosi = (p / 2 < B) ? tbit(txw[i], p / 2) : 1'b0;
      end else if (k[i] == len + 1) begin
        e_done = 1'b1;
      end
      if (chk_en) begin
        chk($sformatf("sclk%0d", i), o_sclk[i], e_sclk);
        chk($sformatf("ss_n%0d", i), o_ss_n[i], e_ss);
        chk($sformatf("mosi%0d", i), o_mosi[i], e_mosi);
        chk($sformatf("busy%0d", i), o_busy[i], e_busy);
        chk($sformatf("done%0d", i), o_done[i], e_done);
        chk($sformatf("rx_data%0d", i), o_rx[i], rexp[i]);
      end
      if (rst_d[i]) begin
        if (!(k[i] >= 1 && k[i] <= len)) rexp[i] = '0;
        k[i] = 0;
      end else if (k[i] >= 1 && k[i] <= len) begin
        if (k[i] % cd == 0 && p % 2 == 0 && p < 2 * B) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
          racc[i] = {i_miso[i], racc[i][B-1:1]};
`else
          racc[i] = {racc[i][B-2:0], i_miso[i]};
`endif
        end
        k[i]++;
        if (k[i] == len + 1) rexp[i] = racc[i];
      end else if (start_d[i]) begin
        k[i]    = 1;
        txw[i]  = tx_d[i];
        racc[i] = '0;
      end else begin
        k[i] = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int i, output logic [B-1:0] rx, output int rises,
                           output int sslow, output bit busy_at_done);
    logic prev;
    int   t;
    rises = 0; sslow = 0; t = 0; prev = o_sclk[i];
    while (t < 400) begin
      if (o_sclk[i] && !prev) rises++;
      prev = o_sclk[i];
      if (!o_ss_n[i]) sslow++;
      if (o_done[i]) break;
      cyc(1);
      t++;
    end
    chk($sformatf("done_seen%0d", i), o_done[i], 1'b1);
    rx           = o_rx[i];
    busy_at_done = o_busy[i];
  endtask

  task automatic run_word(input int i, input logic [B-1:0] tx, output logic [B-1:0] rx,
                          output int rises, output int sslow, output bit busy_at_done);
    tx_d[i] = tx; start_d[i] = 1'b1;
    cyc(1);
    start_d[i] = 1'b0;
    wait_done(i, rx, rises, sslow, busy_at_done);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      rnd_miso[0] = 1'($urandom);
      rnd_miso[1] = 1'($urandom);
    end
  end

  initial begin
    logic [B-1:0] rx;
    int rs, sl, t, gap;
    bit bd;
    logic prev;
    rst_d = '{1'b1, 1'b1}; start_d = '{1'b0, 1'b0}; tx_d = '{8'h00, 8'h00};
    mode = '{0, 0}; rnd_miso = '{1'b0, 1'b0};
    cyc(3);
    rst_d = '{1'b0, 1'b0};
    chk_en = 1'b1;

    chk("rst_sclk", o_sclk[0], 1'b0);
    chk("rst_ss_n", o_ss_n[0], 1'b1);
    chk("rst_mosi", o_mosi[0], 1'b0);
    chk("rst_busy", o_busy[0], 1'b0);
    chk("rst_done", o_done[0], 1'b0);
    chk("rst_rx", o_rx[0], 8'h00);

    // loopback 0xAC at CLK_DIV=2
    run_word(0, 8'hAC, rx, rs, sl, bd);
    chk("lb_rx", rx, 8'hAC);
    chk("lb_rises", rs, 8);
    chk("lb_ss_low", sl, 34);
    chk("lb_busy_at_done", bd, 1'b0);
    cyc(1);
    chk("done_width", o_done[0], 1'b0);

    mode[0] = 1;
    run_word(0, 8'h00, rx, rs, sl, bd);
    chk("tie1_rx", rx, 8'hFF);
    mode[0] = 2;
    run_word(0, 8'hA5, rx, rs, sl, bd);
    chk("tie0_rx", rx, 8'h00);
    mode[0] = 0;
    cyc(2);

    // start hammered during the transfer with junk tx_data
    tx_d[0] = 8'h3C; start_d[0] = 1'b1;
    cyc(1);
    t = 0; sl = 0;
    while (t < 400) begin
      tx_d[0] = B'($urandom);
      if (!o_ss_n[0]) sl++;
      if (o_done[0]) break;
      cyc(1);
      t++;
    end
    start_d[0] = 1'b0;
    chk("spam_done", o_done[0], 1'b1);
    chk("spam_rx", o_rx[0], 8'h3C);
    chk("spam_ss_low", sl, 34);
    cyc(2);
    chk("spam_idle", o_busy[0], 1'b0);

    // back-to-back words at CLK_DIV=1 with start held high
    tx_d[1] = 8'h5A; start_d[1] = 1'b1;
    cyc(1);
    tx_d[1] = 8'hC3;
    wait_done(1, rx, rs, sl, bd);
    chk("b2b_rx0", rx, 8'h5A);
    chk("b2b_rises0", rs, 8);
    chk("b2b_ss_low0", sl, 17);
    gap = 0;
    while (o_ss_n[1] && gap < 10) begin
      gap++;
      cyc(1);
    end
    start_d[1] = 1'b0;
    chk("b2b_gap", gap, 1);
    wait_done(1, rx, rs, sl, bd);
    chk("b2b_rx1", rx, 8'hC3);
    chk("b2b_ss_low1", sl, 17);

    // abort at the 4th sclk rising edge
    tx_d[0] = 8'hE7; start_d[0] = 1'b1;
    cyc(1);
    start_d[0] = 1'b0;
    rs = 0; t = 0; prev = 1'b0;
    while (rs < 4 && t < 200) begin
      if (o_sclk[0] && !prev) rs++;
      prev = o_sclk[0];
      if (rs < 4) begin
        cyc(1);
        t++;
      end
    end
    chk("abort_rises", rs, 4);
    rst_d[0] = 1'b1;
    cyc(1);
    rst_d[0] = 1'b0;
    chk("abort_ss_n", o_ss_n[0], 1'b1);
    chk("abort_sclk", o_sclk[0], 1'b0);
    chk("abort_busy", o_busy[0], 1'b0);
    chk("abort_rx", o_rx[0], 8'h3C);
    cyc(5);
    chk("abort_nodone", o_done[0], 1'b0);
    run_word(0, 8'h0F, rx, rs, sl, bd);
    chk("post_abort_rx", rx, 8'h0F);
    chk("post_abort_ss_low", sl, 34);

    // bit order: first mosi bit of 0x01
    tx_d[0] = 8'h01; start_d[0] = 1'b1;
    cyc(1);
    start_d[0] = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
    chk("first_mosi", o_mosi[0], 1'b1);
`else
    chk("first_mosi", o_mosi[0], 1'b0);
`endif
    wait_done(0, rx, rs, sl, bd);
    chk("order_rx", rx, 8'h01);
    cyc(1);

    // randomized traffic on both instances, model checks every cycle
    for (int blk = 0; blk < 10; blk++) begin
      mode[0] = ($urandom_range(0, 1) == 0) ? 0 : 3;
      mode[1] = $urandom_range(0, 3);
      repeat (300) begin
        for (int i = 0; i < 2; i++) begin
          start_d[i] = ($urandom_range(0, 3) == 0);
          tx_d[i]    = B'($urandom);
          rst_d[i]   = ($urandom_range(0, 249) == 0);
        end
        cyc(1);
      end
    end
    start_d = '{1'b0, 1'b0};
    rst_d   = '{1'b0, 1'b0};
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
